// File: rtl/fib_display_pkg.sv
// Shared constants for the Fibonacci value display: FSM states, segment
// patterns, anode patterns and the double-dabble step helper.
package fib_display_pkg;

  localparam int VAL_W       = 6;
  localparam int SHIFT_COUNT = 6;
  localparam int CNT_W       = 3;
  localparam int SREG_W      = 8 + VAL_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Active-low segments, bit order g..a
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] ONES_ON = 4'b1110;
  localparam logic [3:0] TENS_ON = 4'b1101;
  localparam logic [3:0] ALL_OFF = 4'b1111;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // once doubled, so bias it by 3 before the shift.
  function automatic logic [3:0] dd_adj(logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/fib_display_if.sv
// Value input and 7-segment outputs of the display block.
interface fib_display_if;
  import fib_display_pkg::*;

  logic [VAL_W-1:0] value;
  logic [6:0]       seg;
  logic [3:0]       an;
  logic             dp;

  modport master (output value, input seg, an, dp);
  modport slave  (input value, output seg, an, dp);
endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes blank.
module seg7_decode
  import fib_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pure lookup from digit to segment pattern
  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/fib_display.sv
// Converts a 6-bit count to two BCD digits with a serial double-dabble and
// multiplexes them onto a 4-digit common-anode display, blanking a leading 0.
module fib_display
  import fib_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  fib_display_if.slave d
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t            state, nstate;
  logic [VAL_W-1:0]  last_val;
  logic [SREG_W-1:0] sreg, adj;
  logic [CNT_W-1:0]  bit_cnt;
  logic [3:0]        tens, ones, digit;
  logic [RW-1:0]     rcnt;
  logic              sel;

  // BCD field sits above the binary bits; correct both nibbles before shifting
  assign adj = {dd_adj(sreg[SREG_W-1 -: 4]), dd_adj(sreg[SREG_W-5 -: 4]), sreg[VAL_W-1:0]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  // Next state: capture on change, six shifts, one commit, then recompare
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (d.value != last_val) nstate = SHIFT;
      SHIFT:   if (bit_cnt == CNT_W'(SHIFT_COUNT - 1)) nstate = COMMIT;
      COMMIT:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Conversion datapath; value is only looked at while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_val <= '0;
      sreg     <= '0;
      bit_cnt  <= '0;
      tens     <= '0;
      ones     <= '0;
    end else begin
      case (state)
        IDLE: if (d.value != last_val) begin
          last_val <= d.value;
          sreg     <= {8'd0, d.value};
          bit_cnt  <= '0;
        end
        SHIFT: begin
          sreg    <= adj << 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        COMMIT: begin
          tens <= sreg[SREG_W-1 -: 4];
          ones <= sreg[SREG_W-5 -: 4];
        end
        default: ;
      endcase
    end
  end

  // Refresh divider toggling the active digit on each wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt <= '0;
      sel  <= 1'b0;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      sel  <= ~sel;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  // Digit mux and anode select from registered state only
  always_comb begin
    digit = sel ? tens : ones;
    d.an  = ONES_ON;
    if (sel) d.an = (tens != 4'd0) ? TENS_ON : ALL_OFF;
  end

  seg7_decode u_dec (.digit(digit), .seg(d.seg));

  assign d.dp = 1'b1;

endmodule

// File: doc/fib_display.md
FIB_DISPLAY -- requirements
Module: fib_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit-select toggle (1 kHz at 100 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port value  input  6  binary count from the Fibonacci counter (0..63), sampled synchronously.
REQ-005 SHALL have port seg  output  7  active-low cathodes, seg[0]=a .. seg[6]=g.
REQ-006 SHALL have port an  output  4  active-low anodes, an[0]=ones digit, an[1]=tens digit.
REQ-007 SHALL have port dp  output  1  decimal point, held 1 (off).

Function
REQ-008 SHALL hold registers: last_val[5:0], shift register, tens[3:0], ones[3:0], bit counter, refresh counter, sel (1 bit), and FSM state.
REQ-009 SHALL implement FSM states IDLE, SHIFT, COMMIT.
REQ-010 In IDLE, on an edge where value != last_val, SHALL latch value into last_val and the shift register, clear the BCD field and bit counter, and go to SHIFT; otherwise stay in IDLE.
REQ-011 In SHIFT, each edge SHALL apply double-dabble: add 3 to any BCD nibble >= 5, then shift left one bit.
REQ-012 SHALL leave SHIFT after exactly 6 shift edges.
REQ-013 In COMMIT, SHALL load tens/ones from the BCD field in one edge, then return to IDLE.
REQ-014 Display latency SHALL be 8 edges from the first edge sampling a new value: 1 capture + 6 shift + 1 commit.
REQ-015 Changes on value during SHIFT/COMMIT SHALL be ignored.
REQ-016 On return to IDLE, value SHALL be recompared, so the display always converges to the final stable value.
REQ-017 tens SHALL never exceed 6 and ones SHALL never exceed 9; value 63 SHALL display 6,3.
REQ-018 Refresh counter SHALL count 0..REFRESH_DIV-1, wrap to 0, and toggle sel on wrap.
REQ-019 When sel=0: an=4'b1110, seg=decode(ones).
REQ-020 When sel=1 and tens!=0: an=4'b1101, seg=decode(tens).
REQ-021 When sel=1 and tens==0: leading-zero blanking, an=4'b1111.
REQ-022 an[3:2] SHALL always be 1.
REQ-023 Decode (g..a, active-low) SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-024 seg and an SHALL be combinational decodes of registered state only (no input-to-output path).

Reset
REQ-025 rst low SHALL immediately clear last_val, tens, ones, shift register, bit counter, refresh counter, and sel, and force state IDLE, including mid-conversion.
REQ-026 During and after reset: an=4'b1110, seg=7'b1000000, dp=1.
REQ-027 After rst deasserts, a nonzero value SHALL trigger a fresh conversion per REQ-010; value 0 SHALL trigger no conversion.

Structure
REQ-028 A shared package SHALL hold: FSM state encodings, the ten segment constants, anode patterns (ONES_ON, TENS_ON, ALL_OFF), and the shift count 6.
REQ-029 SHALL instantiate one combinational sub-module seg7_decode (4-bit digit in, 7-bit active-low segments out), muxed between tens and ones by sel.

Verification (bench uses REFRESH_DIV=4)
REQ-030 Reset: rst=0 with value=21 -> an=1110, seg=1000000, dp=1 while held.
REQ-031 Reset release: value=21 after release -> 8 edges later tens=2, ones=1; sel=0 gives an=1110, seg=1111001; sel=1 gives an=1101, seg=0100100.
REQ-032 Blanking: value=8 -> sel=1 gives an=1111; sel=0 gives an=1110, seg=0000000.
REQ-033 Boundary: value=55 -> 5,5 (seg=0010010 both digits); value=63 -> 6,3 (0000010 / 0110000).
REQ-034 Mid-conversion change: value=13, then 34 at edge 3 of SHIFT -> display shows 1,3 first, then 3,4 within 16 edges of the change.
REQ-035 Mid-conversion reset: rst pulsed low during SHIFT with value=34 -> display immediately 0; 3,4 shown 8 edges after release.
